stream_rr_arbiter: RTL and testbench
====================================

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, data width per requester in bits.
REQ-002 SHALL have parameter N (integer), default 4, number of requesters; legal range 1..32.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the block's only clock.
REQ-004 SHALL have port areset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid  input  N  per-requester valid; bit j belongs to requester j.
REQ-006 SHALL have port i_last  input  N  per-requester end-of-packet flag, qualified by i_valid[j].
REQ-007 SHALL have port i_data  input  N*DW  packed data; requester j occupies bits [(j+1)*DW-1 -: DW].
REQ-008 SHALL have port i_ready  output  N  per-requester ready.
REQ-009 SHALL have port o_valid  output  1  output beat valid.
REQ-010 SHALL have port o_ready  input  1  downstream ready.
REQ-011 SHALL have port o_data  output  DW  output beat data.
REQ-012 SHALL have port o_last  output  1  output end-of-packet flag.
REQ-013 SHALL have port o_sel  output  N  one-hot source of the current output beat; all-zero when o_valid=0.

Function
REQ-014 SHALL define load_en = !o_valid || o_ready (output register empty or draining this cycle).
REQ-015 SHALL compute a one-hot grant among i_valid, round-robin: highest priority at index ptr, then ptr+1, ... wrapping mod N; grant=0 if no i_valid.
REQ-016 SHALL drive i_ready = grant & {N{load_en}} when UNLOCKED, and i_ready = owner_onehot & {N{load_en}} when LOCKED; at most one i_ready bit high.
REQ-017 SHALL treat a beat from requester k as accepted on a clock edge where i_valid[k] && i_ready[k].
REQ-018 SHALL, on accepting a beat from k, register o_data <= i_data[k], o_last <= i_last[k], o_sel <= onehot(k), o_valid <= 1 (latency 1 cycle; throughput 1 beat/cycle).
REQ-019 SHALL, when load_en=1 and no beat is accepted, register o_valid <= 0 and o_sel <= 0; o_data/o_last are don't-care.
REQ-020 SHALL hold o_valid, o_data, o_last, o_sel stable while o_valid=1 and o_ready=0.
REQ-021 SHALL implement FSM states UNLOCKED and LOCKED(owner).
REQ-022 SHALL transition UNLOCKED -> LOCKED(k) on acceptance from k with i_last[k]=0; remain UNLOCKED if i_last[k]=1 (single-beat packet).
REQ-023 SHALL transition LOCKED(k) -> UNLOCKED on acceptance from k with i_last[k]=1; stay LOCKED otherwise, regardless of other requesters' i_valid.
REQ-024 SHALL, in LOCKED(k), grant no requester other than k, even if i_valid[k]=0 (gaps in a packet stall the arbiter).
REQ-025 SHALL update ptr <= (k+1) mod N only on acceptance of a beat with i_last[k]=1; ptr unchanged on non-last beats and idle cycles.
REQ-026 SHALL, for N=1, degenerate to a 1-deep registered stream stage with o_sel=1 whenever o_valid=1.
REQ-027 SHALL never reorder or drop accepted beats; every accepted beat appears exactly once on the output.

Reset
REQ-028 SHALL, while areset=1 (asynchronously), force o_valid=0, o_sel=0, o_last=0, o_data=0, ptr=0, state=UNLOCKED.
REQ-029 SHALL, on reset asserted mid-packet, discard the lock and any held output beat; after release requester 0 has highest priority.
REQ-030 SHALL keep i_ready all-zero only as a consequence of REQ-016 during reset (o_valid=0 so load_en=1; i_ready follows grant).

Verification
REQ-031 SHALL cover: N=4, i_valid=4'b1111, all i_last=1, o_ready=1 -> o_sel sequence 0001,0010,0100,1000,0001, one beat per cycle after 1-cycle latency.
REQ-032 SHALL cover: requester 2 sends 3-beat packet (last on beat 3) while requester 0 is valid -> o_sel=0100 for 3 consecutive beats, then 0001; ptr=3 after packet.
REQ-033 SHALL cover: o_valid=1, o_data=8'hA5, o_ready=0 for 5 cycles -> o_data/o_sel/o_last unchanged, i_ready=0, no acceptance.
REQ-034 SHALL cover: LOCKED(1), i_valid[1] drops for 3 cycles while i_valid[3]=1 -> i_ready[3]=0 throughout, output idles, packet resumes from requester 1.
REQ-035 SHALL cover: areset pulsed mid-packet of requester 3 -> o_valid=0 immediately (asynchronous), after release i_valid=1111 grants requester 0 first.
REQ-036 SHALL cover: random valid/last/o_ready stimulus, 10k cycles -> scoreboard confirms per-requester order, packet contiguity, and no starvation (every waiting requester served within N packets).

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: N-input round-robin stream arbiter with packet locking.
// A packet (beats up to and including i_last) from one requester is never
// interleaved with other requesters. The output is a single register stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// UNLOCKED | between packets; round-robin grant starting at ptr
// LOCKED   | mid-packet; only the owner may be accepted, gaps stall
module stream_rr_arbiter #(
  parameter int DW = 8,
  parameter int N  = 4
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [N-1:0]    i_valid,
  input  logic [N-1:0]    i_last,
  input  logic [N*DW-1:0] i_data,
  output logic [N-1:0]    i_ready,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [DW-1:0]   o_data,
  output logic            o_last,
  output logic [N-1:0]    o_sel
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  owner;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  grant;
  logic [N-1:0]  acc_vec;
  logic          found;
  logic          load_en;
  logic          accept;
  logic          acc_last;
  logic [DW-1:0] acc_data;

  // Output register can take a new beat when empty or draining this cycle.
  assign load_en = !o_valid || o_ready;

  // Round-robin pick: first valid at or above ptr, else first valid below ptr.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && i_valid[j] && (j >= int'(ptr))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && i_valid[j] && (j < int'(ptr))) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // A locked owner keeps ready even while its valid is low, so others stall.
  assign i_ready  = ((state == LOCKED) ? owner : grant) & {N{load_en}};
  assign acc_vec  = i_valid & i_ready;
  assign accept   = |acc_vec;
  assign acc_last = |(acc_vec & i_last);

  // Mux the accepted beat and work out the pointer that follows its owner.
  always_comb begin
    acc_data = '0;
    ptr_nxt  = ptr;
    for (int j = 0; j < N; j++) begin
      if (acc_vec[j]) begin
        acc_data = i_data[j*DW +: DW];
        ptr_nxt  = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
  end

  // Lock tracking and round-robin pointer; both advance only on acceptance.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= UNLOCKED;
      owner <= '0;
      ptr   <= '0;
    end else if (accept) begin
      if (state == UNLOCKED && !acc_last) begin
        state <= LOCKED;
        owner <= acc_vec;
      end else if (state == LOCKED && acc_last) begin
        state <= UNLOCKED;
        owner <= '0;
      end
      if (acc_last) begin
        ptr <= ptr_nxt;
      end
    end
  end

  // Output stage: load on acceptance, empty when free and idle, else hold.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_sel   <= '0;
    end else if (load_en) begin
      if (accept) begin
        o_valid <= 1'b1;
        o_data  <= acc_data;
        o_last  <= acc_last;
        o_sel   <= acc_vec;
      end else begin
        o_valid <= 1'b0;
        o_sel   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed and randomized checks for stream_rr_arbiter (N=4, DW=8).
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            areset;
  logic [N-1:0]    i_valid;
  logic [N-1:0]    i_last;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_ready;
  logic            o_valid;
  logic            o_ready;
  logic [DW-1:0]   o_data;
  logic            o_last;
  logic [N-1:0]    o_sel;

  int n_chk  = 0;
  int n_fail = 0;

  stream_rr_arbiter #(.DW(DW), .N(N)) dut (
    .clk     (clk),
    .areset  (areset),
    .i_valid (i_valid),
    .i_last  (i_last),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_sel   (o_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [N-1:0] s,
                         input logic [DW-1:0] d, input logic l);
    chk({tag, "_valid"}, 32'(o_valid), 32'(v));
    chk({tag, "_sel"},   32'(o_sel),   32'(s));
    chk({tag, "_data"},  32'(o_data),  32'(d));
    chk({tag, "_last"},  32'(o_last),  32'(l));
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l, input logic [N*DW-1:0] d);
    i_valid = v;
    i_last  = l;
    i_data  = d;
  endtask

  // Short reset pulse placed just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    set_in('0, '0, '0);
    o_ready = 1'b1;
    areset  = 1'b1;
    #2 areset = 1'b0;
  endtask

  logic [8:0]    sbq [N][$];
  logic [N-1:0]  src_v;
  logic [N-1:0]  src_l;
  logic [DW-1:0] src_d [N];
  int            wait_cnt [N];
  logic          in_pkt;
  logic [N-1:0]  pkt_sel;
  logic [8:0]    exp_beat;
  int            idx;
  logic          gen;

  initial begin
    // Reset state
    areset  = 1'b1;
    o_ready = 1'b1;
    set_in('0, '0, '0);
    #3;
    chk_out("rst", 1'b0, 4'b0000, 8'h00, 1'b0);
    chk("rst_ready_idle", 32'(i_ready), 32'h0);
    i_valid = 4'b1111;
    #1 chk("rst_ready_grant", 32'(i_ready), 32'h1);

    // Full round-robin with single-beat packets
    do_reset();
    set_in(4'b1111, 4'b1111, 32'h44332211);
    #1;
    chk("rr_lat_valid", 32'(o_valid), 32'h0);
    chk("rr_ready0", 32'(i_ready), 32'h1);
    begin
      logic [N-1:0]  es [5];
      logic [DW-1:0] ed [5];
      es = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      ed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        chk_out($sformatf("rr%0d", c), 1'b1, es[c], ed[c], 1'b1);
      end
    end
    i_valid = '0;
    @(negedge clk);
    chk("rr_idle_valid", 32'(o_valid), 32'h0);
    chk("rr_idle_sel", 32'(o_sel), 32'h0);

    // Requester 2 sends a 3-beat packet while requester 0 waits
    do_reset();
    set_in(4'b0010, 4'b0010, 32'h00001000);
    #1 chk("pk_ready1", 32'(i_ready), 32'h2);
    @(negedge clk);
    chk_out("pk_r1", 1'b1, 4'b0010, 8'h10, 1'b1);
    set_in(4'b0101, 4'b0001, 32'h00C1000A);
    #1 chk("pk_ready2a", 32'(i_ready), 32'h4);
    @(negedge clk);
    chk_out("pk_b1", 1'b1, 4'b0100, 8'hC1, 1'b0);
    i_data = 32'h00C2000A;
    #1 chk("pk_ready2b", 32'(i_ready), 32'h4);
    @(negedge clk);
    chk_out("pk_b2", 1'b1, 4'b0100, 8'hC2, 1'b0);
    set_in(4'b0101, 4'b0101, 32'h00C3000A);
    #1 chk("pk_ready2c", 32'(i_ready), 32'h4);
    @(negedge clk);
    chk_out("pk_b3", 1'b1, 4'b0100, 8'hC3, 1'b1);
    set_in(4'b1001, 4'b1001, 32'h0000000A);
    #1 chk("pk_ptr3", 32'(i_ready), 32'h8);
    i_valid = 4'b0001;
    #1 chk("pk_ready0", 32'(i_ready), 32'h1);
    @(negedge clk);
    chk_out("pk_r0", 1'b1, 4'b0001, 8'h0A, 1'b1);
    i_valid = '0;

    // Back-pressure holds the output beat
    do_reset();
    set_in(4'b0001, 4'b0011, 32'h00005AA5);
    i_valid = 4'b0001;
    #1 chk("bp_ready0", 32'(i_ready), 32'h1);
    @(negedge clk);
    chk_out("bp_load", 1'b1, 4'b0001, 8'hA5, 1'b1);
    o_ready = 1'b0;
    i_valid = 4'b0011;
    #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_out($sformatf("bp_hold%0d", c), 1'b1, 4'b0001, 8'hA5, 1'b1);
      chk($sformatf("bp_ready%0d", c), 32'(i_ready), 32'h0);
    end
    o_ready = 1'b1;
    i_valid = '0;
    @(negedge clk);
    chk("bp_drain", 32'(o_valid), 32'h0);

    // Gap inside a locked packet stalls other requesters
    do_reset();
    set_in(4'b0010, 4'b0000, 32'hD300B100);
    #1 chk("gap_ready1", 32'(i_ready), 32'h2);
    @(negedge clk);
    chk_out("gap_b1", 1'b1, 4'b0010, 8'hB1, 1'b0);
    set_in(4'b1000, 4'b1000, 32'hD300B100);
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("gap_ready%0d", c), 32'(i_ready), 32'h2);
      @(negedge clk);
      chk($sformatf("gap_idle%0d", c), 32'(o_valid), 32'h0);
    end
    set_in(4'b1010, 4'b1010, 32'hD300B200);
    #1 chk("gap_resume", 32'(i_ready), 32'h2);
    @(negedge clk);
    chk_out("gap_b2", 1'b1, 4'b0010, 8'hB2, 1'b1);
    i_valid = 4'b1000;
    #1 chk("gap_ready3", 32'(i_ready), 32'h8);
    @(negedge clk);
    chk_out("gap_r3", 1'b1, 4'b1000, 8'hD3, 1'b1);
    i_valid = '0;

    // Asynchronous reset in the middle of a requester 3 packet
    do_reset();
    set_in(4'b1000, 4'b0000, 32'hE1000000);
    #1 chk("ar_ready3", 32'(i_ready), 32'h8);
    @(negedge clk);
    chk_out("ar_b1", 1'b1, 4'b1000, 8'hE1, 1'b0);
    i_data = 32'hE2000000;
    @(negedge clk);
    chk_out("ar_b2", 1'b1, 4'b1000, 8'hE2, 1'b0);
    #1 areset = 1'b1;
    #1 chk_out("ar_async", 1'b0, 4'b0000, 8'h00, 1'b0);
    areset = 1'b0;
    set_in(4'b1111, 4'b1111, 32'h44332211);
    #1 chk("ar_ready0", 32'(i_ready), 32'h1);
    @(negedge clk);
    chk_out("ar_first", 1'b1, 4'b0001, 8'h11, 1'b1);
    i_valid = '0;

    // Random traffic with per-requester scoreboard
    do_reset();
    src_v  = '0;
    src_l  = '0;
    in_pkt = 1'b0;
    pkt_sel = '0;
    for (int j = 0; j < N; j++) begin
      src_d[j]    = '0;
      wait_cnt[j] = 0;
    end
    for (int c = 0; c < 10200; c++) begin
      @(negedge clk);
      gen = (c < 10000);
      for (int j = 0; j < N; j++) begin
        if (gen && !src_v[j] && ($urandom_range(0, 1) == 1)) begin
          src_v[j] = 1'b1;
          src_d[j] = 8'($urandom);
          src_l[j] = ($urandom_range(0, 2) == 0);
        end
      end
      o_ready = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
      i_valid = src_v;
      i_last  = src_l;
      for (int j = 0; j < N; j++) i_data[j*DW +: DW] = src_d[j];
      #1;
      if (o_valid && o_ready) begin
        chk("rnd_onehot", 32'($onehot(o_sel)), 32'h1);
        idx = 0;
        for (int j = 0; j < N; j++) if (o_sel[j]) idx = j;
        if (in_pkt) chk("rnd_contig", 32'(o_sel), 32'(pkt_sel));
        if (sbq[idx].size() == 0) begin
          chk("rnd_spurious", 32'(o_sel), 32'h0);
        end else begin
          exp_beat = sbq[idx].pop_front();
          chk("rnd_beat", 32'({o_last, o_data}), 32'(exp_beat));
        end
        in_pkt  = !o_last;
        pkt_sel = o_sel;
      end
      for (int j = 0; j < N; j++) begin
        if (i_valid[j] && i_ready[j]) begin
          sbq[j].push_back({i_last[j], i_data[j*DW +: DW]});
          src_v[j]    = 1'b0;
          wait_cnt[j] = 0;
          if (i_last[j]) begin
            for (int k = 0; k < N; k++) begin
              if (k != j && src_v[k]) begin
                wait_cnt[k]++;
                chk($sformatf("rnd_starve%0d", k), 32'(wait_cnt[k] < N), 32'h1);
              end
            end
          end
        end
      end
      for (int j = 0; j < N; j++) if (!src_v[j]) wait_cnt[j] = 0;
    end
    for (int j = 0; j < N; j++) chk($sformatf("rnd_drain%0d", j), 32'(sbq[j].size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
